// File: rtl/flash_arb_pkg.sv
// Shared definitions for the flash read arbiter: FSM encoding, requester
// count and the fixed Avalon sideband values.
package flash_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2,
    DONE      = 2'd3
  } arb_state_e;

  localparam int         NUM_REQ        = 2;
  localparam logic [3:0] BYTEENABLE_ALL = 4'b1111;
  localparam logic [5:0] BURST_ONE      = 6'd1;

  function automatic logic [NUM_REQ-1:0] grant_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester wins outright,
// a tie goes to the requester that was not granted last.
module rr_arb2
  import flash_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               last_grant_i,
  output logic               grant_o,
  output logic               valid_o
);

  always_comb begin
    grant_o = req_i[1];
    if (req_i == 2'b11) begin
      grant_o = ~last_grant_i;
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/flash_read_arbiter.sv
// Shares one Avalon-MM flash read master between two requesters, running one
// single-word read at a time with a readdatavalid timeout.
module flash_read_arbiter
  import flash_arb_pkg::*;
#(
  parameter int ADDR_W         = 23,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               inclk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [ADDR_W-1:0]  req_addr0,
  input  logic [ADDR_W-1:0]  req_addr1,
  output logic [NUM_REQ-1:0] rd_done,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_error,
  output logic               busy,
  output logic               flash_mem_read,
  output logic [ADDR_W-1:0]  flash_mem_address,
  output logic [3:0]         flash_mem_byteenable,
  output logic [5:0]         flash_mem_burstcount,
  input  logic               flash_mem_waitrequest,
  input  logic [DATA_W-1:0]  flash_mem_readdata,
  input  logic               flash_mem_readdatavalid
);

  // Counter holds the number of WAIT_DATA cycles already spent, so the
  // timeout fires on the TIMEOUT_CYCLES-th one.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              read_q, read_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              arb_grant;
  logic              arb_valid;

  rr_arb2 u_rr_arb2 (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .valid_o      (arb_valid)
  );

  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      read_q       <= 1'b0;
      data_q       <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      read_q       <= read_d;
      data_q       <= data_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    read_d       = read_q;
    data_d       = data_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d      = arb_grant;
          last_grant_d = arb_grant;
          addr_d       = arb_grant ? req_addr1 : req_addr0;
          read_d       = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (!flash_mem_waitrequest) begin
          read_d = 1'b0;
          cnt_d  = '0;
          // A slave may return data in the accept cycle itself.
          if (flash_mem_readdatavalid) begin
            data_d  = flash_mem_readdata;
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            state_d = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        cnt_d = cnt_q + 8'd1;
        if (flash_mem_readdatavalid) begin
          data_d  = flash_mem_readdata;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rd_done              = (state_q == DONE) ? grant_onehot(grant_q) : '0;
  assign rd_data              = data_q;
  assign rd_error             = err_q;
  assign busy                 = (state_q != IDLE);
  assign flash_mem_read       = read_q;
  assign flash_mem_address    = addr_q;
  assign flash_mem_byteenable = BYTEENABLE_ALL;
  assign flash_mem_burstcount = BURST_ONE;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench: a per-cycle vector table plus hand-written sequences for
// waitrequest stalls, timeout and mid-transaction reset.
module tb_flash_read_arbiter;

  localparam int AW = 23;
  localparam int DW = 32;

  logic          inclk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req = '0;
  logic [AW-1:0] req_addr0 = '0;
  logic [AW-1:0] req_addr1 = '0;
  logic [1:0]    rd_done;
  logic [DW-1:0] rd_data;
  logic          rd_error;
  logic          busy;
  logic          flash_mem_read;
  logic [AW-1:0] flash_mem_address;
  logic [3:0]    flash_mem_byteenable;
  logic [5:0]    flash_mem_burstcount;
  logic          flash_mem_waitrequest = 1'b0;
  logic [DW-1:0] flash_mem_readdata = '0;
  logic          flash_mem_readdatavalid = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 inclk = ~inclk;

  flash_read_arbiter #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .inclk                   (inclk),
    .reset                   (reset),
    .req                     (req),
    .req_addr0               (req_addr0),
    .req_addr1               (req_addr1),
    .rd_done                 (rd_done),
    .rd_data                 (rd_data),
    .rd_error                (rd_error),
    .busy                    (busy),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_byteenable    (flash_mem_byteenable),
    .flash_mem_burstcount    (flash_mem_burstcount),
    .flash_mem_waitrequest   (flash_mem_waitrequest),
    .flash_mem_readdata      (flash_mem_readdata),
    .flash_mem_readdatavalid (flash_mem_readdatavalid)
  );

  // One record per clock cycle: inputs held for the cycle, outputs expected in it.
  typedef struct {
    logic          rst;
    logic [1:0]    rq;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic          wr;
    logic          rdv;
    logic [DW-1:0] rdata;
    logic          e_read;
    logic [AW-1:0] e_addr;
    logic [1:0]    e_done;
    logic [DW-1:0] e_data;
    logic          e_err;
    logic          e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic [1:0] rq,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic wr, input logic rdv, input logic [DW-1:0] rdata,
                              input logic e_read, input logic [AW-1:0] e_addr,
                              input logic [1:0] e_done, input logic [DW-1:0] e_data,
                              input logic e_err, input logic e_busy);
    vec_t v;
    v.rst = rst; v.rq = rq; v.a0 = a0; v.a1 = a1; v.wr = wr; v.rdv = rdv; v.rdata = rdata;
    v.e_read = e_read; v.e_addr = e_addr; v.e_done = e_done; v.e_data = e_data;
    v.e_err = e_err; v.e_busy = e_busy;
    vecs.push_back(v);
  endfunction

  task automatic cyc(input string nm, input logic rst, input logic [1:0] rq,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic wr, input logic rdv, input logic [DW-1:0] rdata,
                     input logic e_read, input logic [AW-1:0] e_addr,
                     input logic [1:0] e_done, input logic [DW-1:0] e_data,
                     input logic e_err, input logic e_busy);
    @(posedge inclk);
    #1;
    reset = rst; req = rq; req_addr0 = a0; req_addr1 = a1;
    flash_mem_waitrequest = wr; flash_mem_readdatavalid = rdv; flash_mem_readdata = rdata;
    @(negedge inclk);
    n_vec++;
    if (flash_mem_read !== e_read || flash_mem_address !== e_addr || rd_done !== e_done ||
        rd_data !== e_data || rd_error !== e_err || busy !== e_busy ||
        flash_mem_byteenable !== 4'hF || flash_mem_burstcount !== 6'd1) begin
      n_err++;
      $display("FAIL %s: got read=%0b addr=%h done=%b data=%h err=%0b busy=%0b be=%h bc=%0d; want read=%0b addr=%h done=%b data=%h err=%0b busy=%0b be=f bc=1",
               nm, flash_mem_read, flash_mem_address, rd_done, rd_data, rd_error, busy,
               flash_mem_byteenable, flash_mem_burstcount,
               e_read, e_addr, e_done, e_data, e_err, e_busy);
    end else begin
      $display("ok   %s: read=%0b addr=%h done=%b data=%h err=%0b busy=%0b",
               nm, flash_mem_read, flash_mem_address, rd_done, rd_data, rd_error, busy);
    end
  endtask

  initial begin
    logic [AW-1:0] a, pa;
    logic [DW-1:0] d, pd;
    logic [1:0]    dn;

    // Single read from requester 0, readdatavalid one cycle after accept.
    add(1, 2'b00, 23'h10, 0, 0, 0, 0,             0, 0,     2'b00, 0, 0, 0);
    add(0, 2'b01, 23'h10, 0, 0, 0, 0,             0, 0,     2'b00, 0, 0, 0);
    add(0, 2'b01, 23'h10, 0, 0, 0, 0,             1, 23'h10, 2'b00, 0, 0, 1);
    add(0, 2'b01, 23'h10, 0, 0, 1, 32'hDEADBEEF,  0, 23'h10, 2'b00, 0, 0, 1);
    add(0, 2'b00, 23'h10, 0, 0, 0, 0,             0, 23'h10, 2'b01, 32'hDEADBEEF, 0, 1);
    add(0, 2'b00, 23'h10, 0, 0, 0, 0,             0, 23'h10, 2'b00, 32'hDEADBEEF, 0, 0);

    // Both requesting: reset restores last_grant so 0 wins, then strict alternation.
    add(1, 2'b00, 23'h100, 23'h200, 0, 0, 0,      0, 0, 2'b00, 0, 0, 0);
    pa = '0;
    pd = '0;
    for (int k = 0; k < 4; k++) begin
      a  = (k % 2 == 0) ? 23'h100 : 23'h200;
      dn = (k % 2 == 0) ? 2'b01 : 2'b10;
      d  = 32'hA000_0000 + 32'(k);
      add(0, 2'b11, 23'h100, 23'h200, 0, 0, 0,    0, pa, 2'b00, pd, 0, 0);
      add(0, 2'b11, 23'h100, 23'h200, 0, 0, 0,    1, a,  2'b00, pd, 0, 1);
      add(0, 2'b11, 23'h100, 23'h200, 0, 1, d,    0, a,  2'b00, pd, 0, 1);
      add(0, 2'b11, 23'h100, 23'h200, 0, 0, 0,    0, a,  dn,    d,  0, 1);
      pa = a;
      pd = d;
    end
    add(0, 2'b00, 23'h100, 23'h200, 0, 0, 0,      0, 23'h200, 2'b00, pd, 0, 0);

    // readdatavalid in the same cycle waitrequest is low: straight to DONE.
    add(1, 2'b00, 23'h3, 0, 0, 0, 0,              0, 0,     2'b00, 0, 0, 0);
    add(0, 2'b01, 23'h3, 0, 0, 0, 0,              0, 0,     2'b00, 0, 0, 0);
    add(0, 2'b01, 23'h3, 0, 0, 1, 32'h12345678,   1, 23'h3, 2'b00, 0, 0, 1);
    add(0, 2'b00, 23'h3, 0, 0, 0, 0,              0, 23'h3, 2'b01, 32'h12345678, 0, 1);
    add(0, 2'b00, 23'h3, 0, 0, 0, 0,              0, 23'h3, 2'b00, 32'h12345678, 0, 0);

    // Lone requester 1.
    add(1, 2'b00, 0, 23'h55, 0, 0, 0,             0, 0,      2'b00, 0, 0, 0);
    add(0, 2'b10, 0, 23'h55, 0, 0, 0,             0, 0,      2'b00, 0, 0, 0);
    add(0, 2'b10, 0, 23'h55, 0, 0, 0,             1, 23'h55, 2'b00, 0, 0, 1);
    add(0, 2'b10, 0, 23'h55, 0, 1, 32'h5555,      0, 23'h55, 2'b00, 0, 0, 1);
    add(0, 2'b00, 0, 23'h55, 0, 0, 0,             0, 23'h55, 2'b10, 32'h5555, 0, 1);

    repeat (2) @(posedge inclk);

    foreach (vecs[i]) begin
      cyc($sformatf("vec%0d", i), vecs[i].rst, vecs[i].rq, vecs[i].a0, vecs[i].a1,
          vecs[i].wr, vecs[i].rdv, vecs[i].rdata, vecs[i].e_read, vecs[i].e_addr,
          vecs[i].e_done, vecs[i].e_data, vecs[i].e_err, vecs[i].e_busy);
    end

    // Waitrequest held 5 cycles after read asserts: read/address stable 6 cycles.
    cyc("wr_reset", 1, 2'b00, 0, 0, 0, 0, 0,           0, 0, 2'b00, 0, 0, 0);
    cyc("wr_idle",  0, 2'b01, 23'h777, 0, 1, 0, 0,     0, 0, 2'b00, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc($sformatf("wr_stall%0d", k), 0, 2'b01, 23'h777, 0, 1, 0, 0,
          1, 23'h777, 2'b00, 0, 0, 1);
    end
    cyc("wr_accept", 0, 2'b01, 23'h777, 0, 0, 0, 0,    1, 23'h777, 2'b00, 0, 0, 1);
    cyc("wr_wait",   0, 2'b01, 23'h777, 0, 0, 1, 32'hCAFEF00D, 0, 23'h777, 2'b00, 0, 0, 1);
    cyc("wr_done",   0, 2'b00, 23'h777, 0, 0, 0, 0,    0, 23'h777, 2'b01, 32'hCAFEF00D, 0, 1);
    cyc("wr_idle2",  0, 2'b00, 23'h777, 0, 0, 0, 0,    0, 23'h777, 2'b00, 32'hCAFEF00D, 0, 0);

    // Timeout after 8 WAIT_DATA cycles; late readdatavalid ignored; error clears next read.
    cyc("to_idle",  0, 2'b10, 0, 23'h42, 0, 0, 0,      0, 23'h777, 2'b00, 32'hCAFEF00D, 0, 0);
    cyc("to_issue", 0, 2'b10, 0, 23'h42, 0, 0, 0,      1, 23'h42, 2'b00, 32'hCAFEF00D, 0, 1);
    for (int k = 0; k < 8; k++) begin
      cyc($sformatf("to_wait%0d", k), 0, 2'b10, 0, 23'h42, 0, 0, 0,
          0, 23'h42, 2'b00, 32'hCAFEF00D, 0, 1);
    end
    cyc("to_done",  0, 2'b00, 0, 23'h42, 0, 0, 0,      0, 23'h42, 2'b10, 0, 1, 1);
    cyc("to_late",  0, 2'b00, 0, 23'h42, 0, 1, 32'hBAD, 0, 23'h42, 2'b00, 0, 1, 0);
    cyc("to_after", 0, 2'b00, 0, 23'h42, 0, 0, 0,      0, 23'h42, 2'b00, 0, 1, 0);
    cyc("ok_idle",  0, 2'b01, 23'h9, 0, 0, 0, 0,       0, 23'h42, 2'b00, 0, 1, 0);
    cyc("ok_issue", 0, 2'b01, 23'h9, 0, 0, 0, 0,       1, 23'h9, 2'b00, 0, 1, 1);
    cyc("ok_wait",  0, 2'b01, 23'h9, 0, 0, 1, 32'h11,  0, 23'h9, 2'b00, 0, 1, 1);
    cyc("ok_done",  0, 2'b00, 23'h9, 0, 0, 0, 0,       0, 23'h9, 2'b01, 32'h11, 0, 1);
    cyc("ok_idle2", 0, 2'b00, 23'h9, 0, 0, 0, 0,       0, 23'h9, 2'b00, 32'h11, 0, 0);

    // Asynchronous reset in WAIT_DATA, then a stray readdatavalid.
    cyc("rs_idle",  0, 2'b01, 23'h20, 0, 0, 0, 0,      0, 23'h9, 2'b00, 32'h11, 0, 0);
    cyc("rs_issue", 0, 2'b01, 23'h20, 0, 0, 0, 0,      1, 23'h20, 2'b00, 32'h11, 0, 1);
    cyc("rs_wait",  0, 2'b01, 23'h20, 0, 0, 0, 0,      0, 23'h20, 2'b00, 32'h11, 0, 1);
    cyc("rs_assert", 1, 2'b00, 23'h20, 0, 0, 0, 0,     0, 0, 2'b00, 0, 0, 0);
    cyc("rs_stray", 0, 2'b00, 23'h20, 0, 0, 1, 32'hBAD, 0, 0, 2'b00, 0, 0, 0);
    cyc("rs_quiet", 0, 2'b00, 23'h20, 0, 0, 0, 0,      0, 0, 2'b00, 0, 0, 0);
    cyc("rs_req1",  0, 2'b10, 0, 23'h30, 0, 0, 0,      0, 0, 2'b00, 0, 0, 0);
    cyc("rs_issue1", 0, 2'b10, 0, 23'h30, 0, 0, 0,     1, 23'h30, 2'b00, 0, 0, 1);
    cyc("rs_wait1", 0, 2'b10, 0, 23'h30, 0, 1, 32'h77, 0, 23'h30, 2'b00, 0, 0, 1);
    cyc("rs_done1", 0, 2'b00, 0, 23'h30, 0, 0, 0,      0, 23'h30, 2'b10, 32'h77, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
